// File: rtl/rst_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : rst_seq_pkg                                                     |
// | Purpose  : Shared state encoding and width helpers for the reset release  |
// |            sequencer (rst_seq).                                            |
// | Contents : ST_HOLD / ST_SEQ / ST_DONE  2-bit state codes                  |
// |            clog2()                     ceiling log2 for width derivation  |
// |            max_of()                    larger of two ints                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package rst_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_HOLD = 2'd0;  // soft hold, every output asserted
  localparam state_t ST_SEQ  = 2'd1;  // releasing outputs in order
  localparam state_t ST_DONE = 2'd2;  // everything released

  // Ceiling log2; clog2(1) == 0, callers clamp where a zero width is illegal.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : rst_seq                                                         |
// | Purpose  : Releases NUM_OUTS active-low block resets one at a time, bit 0 |
// |            first, STAGE_DELAY cycles apart. A soft-reset request          |
// |            re-asserts every output, holds for SOFT_HOLD cycles, then      |
// |            replays the release sequence.                                  |
// | Ports    : CLK           in   system clock                                |
// |            RST           in   async active-low reset (pre-synchronized)   |
// |            SOFT_RST_REQ  in   sync active-high soft-reset request         |
// |            RST_OUT       out  [NUM_OUTS] active-low block resets          |
// |            SEQ_DONE      out  every RST_OUT bit released                  |
// |            BUSY          out  holding or sequencing (== !SEQ_DONE)        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUTS    = 3,
  parameter int STAGE_DELAY = 16,
  parameter int SOFT_HOLD   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SOFT_RST_REQ,
  output logic [NUM_OUTS-1:0] RST_OUT,
  output logic                SEQ_DONE,
  output logic                BUSY
);

  localparam int CNT_RAW = clog2(max_of(STAGE_DELAY, SOFT_HOLD));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int IDX_W   = clog2(NUM_OUTS) + 1;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUTS - 1);

  generate
    if (NUM_OUTS < 1) begin : g_chk_num_outs
      $error("rst_seq: NUM_OUTS must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_chk_stage_delay
      $error("rst_seq: STAGE_DELAY must be >= 1");
    end
    if (SOFT_HOLD < 1) begin : g_chk_soft_hold
      $error("rst_seq: SOFT_HOLD must be >= 1");
    end
  endgenerate

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                done_q,    done_d;
  logic                busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    busy_d    = busy_q;

    // A request overrides anything else on the same edge, including a
    // release that would otherwise happen, and restarts an ongoing hold.
    if (SOFT_RST_REQ) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_SEQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_SEQ: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int i = 0; i < NUM_OUTS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rst_out_d[i] = 1'b1;
              end
            end
            // Done/busy flip on the same edge as the final release so the
            // status flops never disagree with RST_OUT.
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
        end

        default: begin
          // Unreachable encoding: fall back to a full hold, outputs asserted.
          state_d   = ST_HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  // Power-up lands directly in ST_SEQ so sequencing begins on the first edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_SEQ;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Every output is a flop so downstream async resets see no decode glitches.
  assign RST_OUT  = rst_out_q;
  assign SEQ_DONE = done_q;
  assign BUSY     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_rst_seq                                                      |
// | Purpose  : Directed self-checking bench for rst_seq. Main instance uses    |
// |            NUM_OUTS=3, STAGE_DELAY=4, SOFT_HOLD=2; a corner instance uses  |
// |            NUM_OUTS=1, STAGE_DELAY=1.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       soft_req;
  logic       soft_req_c;
  logic [2:0] rst_out;
  logic       seq_done;
  logic       busy;
  logic [0:0] rst_out_c;
  logic       seq_done_c;
  logic       busy_c;

  int n_tests;
  int n_fail;

  rst_seq #(.NUM_OUTS(3), .STAGE_DELAY(4), .SOFT_HOLD(2)) u_dut (
    .CLK          (clk),
    .RST          (rst_n),
    .SOFT_RST_REQ (soft_req),
    .RST_OUT      (rst_out),
    .SEQ_DONE     (seq_done),
    .BUSY         (busy)
  );

  rst_seq #(.NUM_OUTS(1), .STAGE_DELAY(1), .SOFT_HOLD(1)) u_dut_corner (
    .CLK          (clk),
    .RST          (rst_n),
    .SOFT_RST_REQ (soft_req_c),
    .RST_OUT      (rst_out_c),
    .SEQ_DONE     (seq_done_c),
    .BUSY         (busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, then release it 1 unit after an edge so the next
  // rising edge is edge 1.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected RST_OUT for the main instance, j edges after the reference edge,
  // when the first release happens at j == first (then every 4 edges).
  function automatic logic [2:0] exp_bits(input int j, input int first);
    int n;
    if (j < first) n = 0;
    else n = (j - first) / 4 + 1;
    if (n > 3) n = 3;
    case (n)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Step edges jstart+1 .. jend and check all three outputs at each.
  task automatic follow(input string tag, input int first, input int jstart, input int jend);
    logic [2:0] e;
    for (int j = jstart + 1; j <= jend; j++) begin
      tick();
      e = exp_bits(j, first);
      chk($sformatf("%s_out_e%0d", tag, j), 32'(rst_out), 32'(e));
      chk($sformatf("%s_done_e%0d", tag, j), 32'(seq_done), 32'(e == 3'b111));
      chk($sformatf("%s_busy_e%0d", tag, j), 32'(busy), 32'(e != 3'b111));
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    soft_req   = 1'b0;
    soft_req_c = 1'b0;
    tick();
    tick();

    // Reset state for both instances.
    chk("rst_out", 32'(rst_out), 32'h0);
    chk("rst_done", 32'(seq_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_c_out", 32'(rst_out_c), 32'h0);
    chk("rst_c_done", 32'(seq_done_c), 32'h0);
    chk("rst_c_busy", 32'(busy_c), 32'h1);

    // Power-up: releases at edges 4, 8, 12. Corner instance finishes at edge 1.
    rst_n = 1'b1;
    tick();
    chk("c_out_e1", 32'(rst_out_c), 32'h1);
    chk("c_done_e1", 32'(seq_done_c), 32'h1);
    chk("c_busy_e1", 32'(busy_c), 32'h0);
    chk("pu_out_e1", 32'(rst_out), 32'h0);
    follow("pu", 4, 1, 14);
    chk("c_done_hold", 32'(seq_done_c), 32'h1);

    // Soft reset from DONE: request sampled at edge E (j=0).
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("sd_out_e0", 32'(rst_out), 32'h0);
    chk("sd_done_e0", 32'(seq_done), 32'h0);
    chk("sd_busy_e0", 32'(busy), 32'h1);
    follow("sd", 6, 0, 16);

    // Soft reset mid-sequence at edge 6: releases at 12, 16, 20.
    do_reset();
    follow("ms_pre", 4, 0, 5);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("ms_out_e6", 32'(rst_out), 32'h0);
    follow("ms", 12, 6, 21);

    // Request collides with the bit-1 release at edge 8.
    do_reset();
    follow("col_pre", 4, 0, 7);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("col_out_e8", 32'(rst_out), 32'h0);
    chk("col_done_e8", 32'(seq_done), 32'h0);
    follow("col", 14, 8, 23);

    // Repeated request during HOLD (E and E+1): first release at E+7.
    soft_req = 1'b1;
    tick();
    tick();
    soft_req = 1'b0;
    chk("rep_out_e1", 32'(rst_out), 32'h0);
    follow("rep", 7, 1, 16);

    // Async reset between edges mid-sequence: outputs drop without a clock edge.
    do_reset();
    follow("ar_pre", 4, 0, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_async", 32'(rst_out), 32'h0);
    chk("ar_done_async", 32'(seq_done), 32'h0);
    chk("ar_busy_async", 32'(busy), 32'h1);
    tick();
    rst_n = 1'b1;
    follow("ar_replay", 4, 0, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
